// File: rtl/if_id_pkg.sv
// Shared types and defaults for the elastic IF/ID pipeline stage.
package if_id_pkg;

    localparam int unsigned DEF_PC_W   = 32;
    localparam int unsigned DEF_INST_W = 32;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_t;

    // All-zero word decodes as a NOP in the downstream decoder.
    localparam logic [DEF_INST_W-1:0] NOP_INST = '0;

endpackage

// File: rtl/if_id_skid_stage_if.sv
// Fetch-to-decode valid/ready handshake bundle; slave is the stage, master drives it.
interface if_id_skid_stage_if
    import if_id_pkg::*;
#(
    parameter int unsigned PC_W   = DEF_PC_W,
    parameter int unsigned INST_W = DEF_INST_W
);

    logic              in_valid_i;
    logic              in_ready_o;
    logic [PC_W-1:0]   in_pc4_i;
    logic [INST_W-1:0] in_inst_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [PC_W-1:0]   out_pc4_o;
    logic [INST_W-1:0] out_inst_o;

    modport slave (
        input  in_valid_i, in_pc4_i, in_inst_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc4_o, out_inst_o
    );

    modport master (
        output in_valid_i, in_pc4_i, in_inst_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc4_o, out_inst_o
    );

endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clock_i,
    input  logic             Reset_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// Elastic IF/ID stage: main + skid register pair, registered ready, flush and activity counters.
module if_id_skid_stage
    import if_id_pkg::*;
#(
    parameter int unsigned PC_W   = DEF_PC_W,
    parameter int unsigned INST_W = DEF_INST_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic             Clock_i,
    input  logic             Reset_i,
    input  logic             Flush_i,
    if_id_skid_stage_if.slave bus,
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    stage_state_t      state_q;
    logic [PC_W-1:0]   main_pc4_q, skid_pc4_q;
    logic [INST_W-1:0] main_inst_q, skid_inst_q;
    logic              in_ready_q, out_valid_q;
    logic              in_hs;

    assign in_hs = bus.in_valid_i & in_ready_q;

    // Main is zeroed whenever it goes empty, so payload outputs need no gating.
    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q     <= EMPTY;
            main_pc4_q  <= '0;
            main_inst_q <= INST_W'(NOP_INST);
            skid_pc4_q  <= '0;
            skid_inst_q <= INST_W'(NOP_INST);
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (Flush_i) begin
            state_q     <= EMPTY;
            main_pc4_q  <= '0;
            main_inst_q <= INST_W'(NOP_INST);
            skid_pc4_q  <= '0;
            skid_inst_q <= INST_W'(NOP_INST);
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_hs) begin
                        main_pc4_q  <= bus.in_pc4_i;
                        main_inst_q <= bus.in_inst_i;
                        out_valid_q <= 1'b1;
                        state_q     <= FULL;
                    end
                end
                FULL: begin
                    if (bus.out_ready_i && in_hs) begin
                        main_pc4_q  <= bus.in_pc4_i;
                        main_inst_q <= bus.in_inst_i;
                    end else if (bus.out_ready_i) begin
                        main_pc4_q  <= '0;
                        main_inst_q <= INST_W'(NOP_INST);
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end else if (in_hs) begin
                        skid_pc4_q  <= bus.in_pc4_i;
                        skid_inst_q <= bus.in_inst_i;
                        in_ready_q  <= 1'b0;
                        state_q     <= SKID;
                    end
                end
                SKID: begin
                    if (bus.out_ready_i) begin
                        main_pc4_q  <= skid_pc4_q;
                        main_inst_q <= skid_inst_q;
                        skid_pc4_q  <= '0;
                        skid_inst_q <= INST_W'(NOP_INST);
                        in_ready_q  <= 1'b1;
                        state_q     <= FULL;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_pc4_o   = main_pc4_q;
    assign bus.out_inst_o  = main_inst_q;

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .Clock_i (Clock_i),
        .Reset_i (Reset_i),
        .inc_i   (out_valid_q & ~bus.out_ready_i),
        .clr_i   (cnt_clr_i),
        .count_o (stall_cnt_o)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .Clock_i (Clock_i),
        .Reset_i (Reset_i),
        .inc_i   (Flush_i & (state_q != EMPTY)),
        .clr_i   (cnt_clr_i),
        .count_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage; a second CNT_W=4 copy shares the stimulus for saturation.
`timescale 1ns/1ps
module tb_if_id_skid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        cnt_clr;
    logic [15:0] stall_cnt, flush_cnt;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int checks = 0;
    int fails  = 0;

    if_id_skid_stage_if #(.PC_W(32), .INST_W(32)) bus ();
    if_id_skid_stage_if #(.PC_W(32), .INST_W(32)) bus4 ();

    assign bus4.in_valid_i  = bus.in_valid_i;
    assign bus4.in_pc4_i    = bus.in_pc4_i;
    assign bus4.in_inst_i   = bus.in_inst_i;
    assign bus4.out_ready_i = bus.out_ready_i;

    if_id_skid_stage #(.PC_W(32), .INST_W(32), .CNT_W(16)) dut (
        .Clock_i     (clk),
        .Reset_i     (rst),
        .Flush_i     (flush),
        .bus         (bus),
        .cnt_clr_i   (cnt_clr),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
    );

    if_id_skid_stage #(.PC_W(32), .INST_W(32), .CNT_W(4)) dut4 (
        .Clock_i     (clk),
        .Reset_i     (rst),
        .Flush_i     (flush),
        .bus         (bus4),
        .cnt_clr_i   (cnt_clr),
        .stall_cnt_o (stall_cnt4),
        .flush_cnt_o (flush_cnt4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic ordy);
        bus.in_valid_i  = v;
        bus.in_inst_i   = inst;
        bus.in_pc4_i    = v ? (32'h1000 + (inst << 2)) : 32'h0;
        bus.out_ready_i = ordy;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] inst,
                             input logic rdy);
        check({tag, "_valid"}, 64'(bus.out_valid_o), 64'(v));
        check({tag, "_inst"}, 64'(bus.out_inst_o), 64'(inst));
        check({tag, "_pc4"}, 64'(bus.out_pc4_o), v ? 64'(32'h1000 + (inst << 2)) : 64'h0);
        check({tag, "_ready"}, 64'(bus.in_ready_o), 64'(rdy));
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        cnt_clr = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        #12;
        check_out("reset", 1'b0, 32'h0, 1'b1);
        check("reset_stall", 64'(stall_cnt), 64'h0);
        check("reset_flush", 64'(flush_cnt), 64'h0);
        rst = 1'b0;

        // Streaming: one cycle latency, full throughput.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 1'b1);
            step();
            check_out($sformatf("stream%0d", i), 1'b1, 32'(i), 1'b1);
        end
        drive(1'b0, 32'h0, 1'b1);
        step();
        check_out("stream_drain", 1'b0, 32'h0, 1'b1);
        check("stream_stall", 64'(stall_cnt), 64'h0);

        // Back-pressure: A accepted, B into skid, C held upstream.
        drive(1'b1, 32'hA, 1'b0);
        step();
        check_out("bp_a", 1'b1, 32'hA, 1'b1);
        drive(1'b1, 32'hB, 1'b0);
        step();
        check_out("bp_b", 1'b1, 32'hA, 1'b0);
        drive(1'b1, 32'hC, 1'b0);
        step();
        check_out("bp_c1", 1'b1, 32'hA, 1'b0);
        step();
        check_out("bp_c2", 1'b1, 32'hA, 1'b0);
        check("bp_stall", 64'(stall_cnt), 64'd3);
        drive(1'b1, 32'hC, 1'b1);
        step();
        check_out("bp_rel_b", 1'b1, 32'hB, 1'b1);
        step();
        check_out("bp_rel_c", 1'b1, 32'hC, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        step();
        check_out("bp_empty", 1'b0, 32'h0, 1'b1);
        check("bp_stall_hold", 64'(stall_cnt), 64'd3);

        // Flush while in SKID with D presented: everything discarded.
        drive(1'b1, 32'h1A, 1'b0);
        step();
        drive(1'b1, 32'h1B, 1'b0);
        step();
        check_out("fl_skid", 1'b1, 32'h1A, 1'b0);
        drive(1'b1, 32'hD, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_out("fl_after", 1'b0, 32'h0, 1'b1);
        check("fl_cnt", 64'(flush_cnt), 64'd1);
        check("fl_stall", 64'(stall_cnt), 64'd5);
        drive(1'b0, 32'h0, 1'b1);
        step();
        check_out("fl_no_d", 1'b0, 32'h0, 1'b1);
        drive(1'b1, 32'hE, 1'b1);
        step();
        check_out("fl_resume", 1'b1, 32'hE, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        step();

        // Flush while EMPTY leaves the flush counter alone.
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_empty_cnt", 64'(flush_cnt), 64'd1);

        // Clear coinciding with a stall cycle wins.
        drive(1'b1, 32'hF, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_stall", 64'(stall_cnt), 64'h0);
        check("clr_flush", 64'(flush_cnt), 64'h0);
        check("clr_stall4", 64'(stall_cnt4), 64'h0);

        // Saturation of the 4-bit copy; 16-bit copy keeps counting.
        for (int i = 0; i < 15; i++) step();
        check("sat4_15", 64'(stall_cnt4), 64'd15);
        for (int i = 0; i < 5; i++) step();
        check("sat4_hold", 64'(stall_cnt4), 64'd15);
        check("sat16_20", 64'(stall_cnt), 64'd20);
        check_out("sat_head", 1'b1, 32'hF, 1'b1);

        // Reset asserted mid-cycle while in SKID.
        drive(1'b1, 32'h11, 1'b0);
        step();
        check_out("pre_rst", 1'b1, 32'hF, 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_out("rst_mid", 1'b0, 32'h0, 1'b1);
        check("rst_mid_stall", 64'(stall_cnt), 64'h0);
        check("rst_mid_stall4", 64'(stall_cnt4), 64'h0);
        #1;
        rst = 1'b0;
        step();
        check_out("rst_gone", 1'b0, 32'h0, 1'b1);
        drive(1'b1, 32'h12, 1'b1);
        step();
        check_out("rst_accept", 1'b1, 32'h12, 1'b1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
